// File: rtl/ysyx_22041071_pipe_ctrl.sv
// Pipeline hazard/flush controller: load-use stalls, memory-wait stalls, redirect flushes.
// Latency: all outputs are combinational from the current state and inputs (zero cycles).
// Backpressure: mem_req & !mem_ack freezes every stage until mem_ack; redirects seen meanwhile are deferred.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset (outputs forced to 0 while high)
//   id_*                  - ID-stage operand usage and source register numbers
//   ex_load/ex_reg_w_en/ex_rdest - EX-stage destination information for the load-use check
//   redirect              - EX resolved a taken branch/jalr this cycle
//   mem_req/mem_ack       - data access outstanding / complete
//   pc_hold..mem_stall    - per-stage hold, bubble and flush controls
//   state_o               - current state (RUN=0, MEM_WAIT=1, FLUSH=2)
//   stall_cnt/flush_cnt   - wrapping perf counters, present only with YSYX_22041071_PERF_CNT_EN defined
module ysyx_22041071_pipe_ctrl #(
  parameter int FLUSH_LEN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_load,
  input  logic        ex_reg_w_en,
  input  logic [4:0]  ex_rdest,
  input  logic        redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_hold,
  output logic        if_stall,
  output logic        id_stall,
  output logic        id_bubble,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic [1:0]  state_o
`ifdef YSYX_22041071_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [2:0] LP_RELOAD = 3'(FLUSH_LEN - 1);
  // With FLUSH_LEN == 1 the redirect cycle itself is the whole flush.
  localparam logic       LP_MULTI  = (FLUSH_LEN > 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_pend, w_pend_nxt;
  // Set when a memory wait interrupted a flush; the remaining count in r_cnt is resumed after ack.
  logic       r_resume, w_resume_nxt;

  logic w_load_use, w_mem_wait;
  logic w_stall5, w_lu, w_flush;

  assign w_load_use = id_valid & ex_load & ex_reg_w_en & (ex_rdest != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rdest)) | (id_use_rs2 & (id_rs2 == ex_rdest)));
  assign w_mem_wait = mem_req & ~mem_ack;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_resume_nxt = r_resume;
    w_stall5     = 1'b0;
    w_lu         = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_stall5     = 1'b1;
          w_state_nxt  = ST_MEM_WAIT;
          w_pend_nxt   = redirect;
          w_resume_nxt = 1'b0;
        end else if (redirect) begin
          w_flush     = 1'b1;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = LP_MULTI ? ST_FLUSH : ST_RUN;
        end else if (w_load_use) begin
          w_lu = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ack) begin
          w_stall5 = 1'b1;
          if (redirect) w_pend_nxt = 1'b1;
        end else if (r_pend | redirect) begin
          // A deferred redirect restarts the flush from the full length.
          w_flush      = 1'b1;
          w_cnt_nxt    = LP_RELOAD;
          w_state_nxt  = LP_MULTI ? ST_FLUSH : ST_RUN;
          w_pend_nxt   = 1'b0;
          w_resume_nxt = 1'b0;
        end else if (r_resume) begin
          w_state_nxt  = ST_FLUSH;
          w_resume_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_mem_wait) begin
          // Flush cycle is deferred: counter untouched so no flush cycle is lost.
          w_stall5     = 1'b1;
          w_state_nxt  = ST_MEM_WAIT;
          w_resume_nxt = 1'b1;
          w_pend_nxt   = redirect;
        end else if (redirect) begin
          w_flush     = 1'b1;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = LP_MULTI ? ST_FLUSH : ST_RUN;
        end else begin
          w_flush     = 1'b1;
          w_cnt_nxt   = r_cnt - 3'd1;
          w_state_nxt = (r_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_cnt    <= 3'd0;
      r_pend   <= 1'b0;
      r_resume <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_resume <= w_resume_nxt;
    end
  end

  // Outputs are forced low while reset is high, independent of the registered state.
  assign pc_hold   = ~reset & (w_stall5 | w_lu);
  assign if_stall  = ~reset & (w_stall5 | w_lu);
  assign id_stall  = ~reset & (w_stall5 | w_lu);
  assign id_bubble = ~reset & w_lu;
  assign if_flush  = ~reset & w_flush;
  assign id_flush  = ~reset & w_flush;
  assign ex_stall  = ~reset & w_stall5;
  assign mem_stall = ~reset & w_stall5;
  assign state_o   = reset ? 2'd0 : r_state;

`ifdef YSYX_22041071_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (pc_hold)  r_stall_cnt <= r_stall_cnt + 32'd1;
      if (if_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ysyx_22041071_pipe_ctrl.sv
// Directed bench for ysyx_22041071_pipe_ctrl with FLUSH_LEN=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Snapshot layout: {state_o, pc_hold, if_stall, id_stall, id_bubble, if_flush, id_flush, ex_stall, mem_stall}.
module tb_ysyx_22041071_pipe_ctrl;

  logic       clk, reset;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2;
  logic       ex_load, ex_reg_w_en;
  logic [4:0] ex_rdest;
  logic       redirect, mem_req, mem_ack;
  logic       pc_hold, if_stall, id_stall, id_bubble, if_flush, id_flush, ex_stall, mem_stall;
  logic [1:0] state_o;
`ifdef YSYX_22041071_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] base_cnt;
`endif

  int total  = 0;
  int passed = 0;

  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] S5   = 8'b1110_0011;
  localparam logic [7:0] LU   = 8'b1111_0000;
  localparam logic [7:0] FL   = 8'b0000_1100;

  ysyx_22041071_pipe_ctrl #(.FLUSH_LEN(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_load(ex_load), .ex_reg_w_en(ex_reg_w_en), .ex_rdest(ex_rdest),
    .redirect(redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(pc_hold), .if_stall(if_stall), .id_stall(id_stall), .id_bubble(id_bubble),
    .if_flush(if_flush), .id_flush(id_flush), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .state_o(state_o)
`ifdef YSYX_22041071_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] snap();
    return {state_o, pc_hold, if_stall, id_stall, id_bubble, if_flush, id_flush, ex_stall, mem_stall};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_load = 0; ex_reg_w_en = 0; ex_rdest = 0;
    redirect = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_hazard(input logic [4:0] rd, input logic [4:0] rs);
    id_valid = 1; id_use_rs1 = 1; id_rs1 = rs; ex_load = 1; ex_reg_w_en = 1; ex_rdest = rd;
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 1; mem_req = 1; redirect = 1; set_hazard(5'd5, 5'd5);
    tick(); tick(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL reset_hold act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
`ifdef YSYX_22041071_PERF_CNT_EN
    total++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt act=%0d exp=0", stall_cnt); else passed++;
`endif
    reset = 0; clear_inputs();
  endtask

  task automatic test_load_use();
    tick(); set_hazard(5'd5, 5'd5); #1;
    total++; if (snap() !== {2'd0, LU}) $display("FAIL lu_rs1 act=%b exp=%b", snap(), {2'd0, LU}); else passed++;
    tick(); clear_inputs(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL lu_release act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); set_hazard(5'd7, 5'd3); id_use_rs2 = 1; id_rs2 = 5'd7; #1;
    total++; if (snap() !== {2'd0, LU}) $display("FAIL lu_rs2 act=%b exp=%b", snap(), {2'd0, LU}); else passed++;
    tick(); clear_inputs(); set_hazard(5'd9, 5'd9); id_use_rs1 = 0; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL lu_unused_rs1 act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); set_hazard(5'd9, 5'd9); id_valid = 0; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL lu_id_invalid act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); set_hazard(5'd0, 5'd0); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL lu_x0 act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); clear_inputs();
  endtask

  task automatic test_redirect();
    tick(); redirect = 1; #1;
    total++; if (snap() !== {2'd0, FL}) $display("FAIL redir_c0 act=%b exp=%b", snap(), {2'd0, FL}); else passed++;
    tick(); redirect = 0; set_hazard(5'd4, 5'd4); #1;
    total++; if (snap() !== {2'd2, FL}) $display("FAIL redir_c1_no_bubble act=%b exp=%b", snap(), {2'd2, FL}); else passed++;
    tick(); clear_inputs(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL redir_done act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
  endtask

  task automatic test_redirect_restart();
    tick(); redirect = 1; #1;
    total++; if (snap() !== {2'd0, FL}) $display("FAIL restart_c0 act=%b exp=%b", snap(), {2'd0, FL}); else passed++;
    tick(); #1;
    total++; if (snap() !== {2'd2, FL}) $display("FAIL restart_c1 act=%b exp=%b", snap(), {2'd2, FL}); else passed++;
    tick(); redirect = 0; #1;
    total++; if (snap() !== {2'd2, FL}) $display("FAIL restart_c2 act=%b exp=%b", snap(), {2'd2, FL}); else passed++;
    tick(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL restart_done act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
  endtask

  task automatic test_mem_wait();
    tick(); mem_req = 1; mem_ack = 1; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL mem_same_cycle_ack act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); mem_ack = 0; #1;
`ifdef YSYX_22041071_PERF_CNT_EN
    base_cnt = stall_cnt;
`endif
    total++; if (snap() !== {2'd0, S5}) $display("FAIL mem_w1 act=%b exp=%b", snap(), {2'd0, S5}); else passed++;
    for (int i = 2; i <= 4; i++) begin
      tick(); #1;
      total++; if (snap() !== {2'd1, S5}) $display("FAIL mem_w%0d act=%b exp=%b", i, snap(), {2'd1, S5}); else passed++;
    end
    tick(); mem_ack = 1; #1;
    total++; if (snap() !== {2'd1, NONE}) $display("FAIL mem_ack act=%b exp=%b", snap(), {2'd1, NONE}); else passed++;
    tick(); clear_inputs(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL mem_done act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
`ifdef YSYX_22041071_PERF_CNT_EN
    total++; if (stall_cnt - base_cnt !== 32'd4) $display("FAIL mem_stall_cnt act=%0d exp=4", stall_cnt - base_cnt); else passed++;
`endif
  endtask

  task automatic test_redirect_in_wait();
    tick(); mem_req = 1; #1;
    total++; if (snap() !== {2'd0, S5}) $display("FAIL rw_w1 act=%b exp=%b", snap(), {2'd0, S5}); else passed++;
    tick(); redirect = 1; #1;
    total++; if (snap() !== {2'd1, S5}) $display("FAIL rw_w2 act=%b exp=%b", snap(), {2'd1, S5}); else passed++;
    tick(); redirect = 0; #1;
    total++; if (snap() !== {2'd1, S5}) $display("FAIL rw_w3 act=%b exp=%b", snap(), {2'd1, S5}); else passed++;
    tick(); #1;
    total++; if (snap() !== {2'd1, S5}) $display("FAIL rw_w4 act=%b exp=%b", snap(), {2'd1, S5}); else passed++;
    tick(); mem_ack = 1; #1;
    total++; if (snap() !== {2'd1, FL}) $display("FAIL rw_ack_flush act=%b exp=%b", snap(), {2'd1, FL}); else passed++;
    tick(); clear_inputs(); #1;
    total++; if (snap() !== {2'd2, FL}) $display("FAIL rw_flush2 act=%b exp=%b", snap(), {2'd2, FL}); else passed++;
    tick(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL rw_done act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
  endtask

  task automatic test_wait_in_flush();
    tick(); redirect = 1; #1;
    total++; if (snap() !== {2'd0, FL}) $display("FAIL wf_c0 act=%b exp=%b", snap(), {2'd0, FL}); else passed++;
    tick(); redirect = 0; mem_req = 1; #1;
    total++; if (snap() !== {2'd2, S5}) $display("FAIL wf_stall act=%b exp=%b", snap(), {2'd2, S5}); else passed++;
    tick(); mem_ack = 1; #1;
    total++; if (snap() !== {2'd1, NONE}) $display("FAIL wf_ack act=%b exp=%b", snap(), {2'd1, NONE}); else passed++;
    tick(); clear_inputs(); #1;
    total++; if (snap() !== {2'd2, FL}) $display("FAIL wf_resume act=%b exp=%b", snap(), {2'd2, FL}); else passed++;
    tick(); #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL wf_done act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
  endtask

  task automatic test_priority();
    tick(); mem_req = 1; redirect = 1; set_hazard(5'd6, 5'd6); #1;
    total++; if (snap() !== {2'd0, S5}) $display("FAIL prio_mem_first act=%b exp=%b", snap(), {2'd0, S5}); else passed++;
    tick(); mem_req = 0; set_hazard(5'd6, 5'd6); #1;
    do_reset();
    tick(); redirect = 1; set_hazard(5'd6, 5'd6); #1;
    total++; if (snap() !== {2'd0, FL}) $display("FAIL prio_redir_over_lu act=%b exp=%b", snap(), {2'd0, FL}); else passed++;
    do_reset();
  endtask

  task automatic test_reset_mid_op();
    tick(); redirect = 1; #1;
    total++; if (snap() !== {2'd0, FL}) $display("FAIL rst_flush_c0 act=%b exp=%b", snap(), {2'd0, FL}); else passed++;
    tick(); redirect = 0; reset = 1; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL rst_flush_hold act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); reset = 0; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL rst_flush_after act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); mem_req = 1; #1;
    tick(); redirect = 1; #1;
    total++; if (snap() !== {2'd1, S5}) $display("FAIL rst_wait_pre act=%b exp=%b", snap(), {2'd1, S5}); else passed++;
    tick(); reset = 1; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL rst_wait_hold act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); reset = 0; clear_inputs(); mem_ack = 1; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL rst_wait_no_pend act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
    tick(); mem_ack = 0; #1;
    total++; if (snap() !== {2'd0, NONE}) $display("FAIL rst_wait_after act=%b exp=%b", snap(), {2'd0, NONE}); else passed++;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_restart();
    test_mem_wait();
    test_redirect_in_wait();
    test_wait_in_flush();
    test_priority();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
